transpose_seq_ctrl: RTL

TRANSPOSE_SEQ_CTRL -- requirements
Module: transpose_seq_ctrl

---
 rtl/transpose_seq_ctrl.sv | 99 +++++++++
 1 files changed

// File: rtl/transpose_seq_ctrl.sv
// Sequencer for an external N x N transposition array: buffers N input rows,
// streams them horizontally into the array, then shifts the transposed rows out.
module transpose_seq_ctrl #(
    parameter int DATA_WIDTH     = 16,
    parameter int SYSTOLIC_WIDTH = 4
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [SYSTOLIC_WIDTH*DATA_WIDTH-1:0] in_data,
    output logic [SYSTOLIC_WIDTH*DATA_WIDTH-1:0] arr_in,
    output logic                                 arr_mode,
    input  logic [SYSTOLIC_WIDTH*DATA_WIDTH-1:0] arr_out,
    output logic                                 out_valid,
    output logic [SYSTOLIC_WIDTH*DATA_WIDTH-1:0] out_data,
    output logic                                 busy,
    output logic                                 frame_done
);
    localparam int N  = SYSTOLIC_WIDTH;
    localparam int W  = N * DATA_WIDTH;
    localparam int CW = $clog2(N) + 1;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {COLLECT, FILL, DRAIN} state_t;

    state_t              state, state_next;
    logic [CW-1:0]       cnt, cnt_next;
    logic [N-1:0][W-1:0] row_buf;
    logic                wr_en;
    logic [IW-1:0]       idx;

    // cnt never exceeds N-1 while used as an index, so the low bits suffice
    assign idx = cnt[IW-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= COLLECT;
            cnt     <= '0;
            row_buf <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (wr_en) row_buf[idx] <= in_data;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        wr_en      = 1'b0;
        in_ready   = 1'b0;
        arr_mode   = 1'b1;
        arr_in     = '0;
        out_valid  = 1'b0;
        out_data   = '0;
        busy       = 1'b0;
        frame_done = 1'b0;
        case (state)
            COLLECT: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    wr_en = 1'b1;
                    if (cnt == LAST) begin
                        cnt_next   = '0;
                        state_next = FILL;
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end
            end
            FILL: begin
                busy     = 1'b1;
                arr_mode = 1'b0;
                arr_in   = row_buf[idx];
                if (cnt == LAST) begin
                    cnt_next   = '0;
                    state_next = DRAIN;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            DRAIN: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_data  = arr_out;
                if (cnt == LAST) begin
                    frame_done = 1'b1;
                    cnt_next   = '0;
                    state_next = COLLECT;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: state_next = COLLECT;
        endcase
    end
endmodule
